// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive sides.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS       = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } uart_rx_state_t;

endpackage

// File: rtl/axis_interface.sv
// Minimal AXI-Stream byte channel; the clock travels with the bundle.
interface axis_interface (
  input logic clk
);

  logic [uart_pkg::UART_DATA_BITS-1:0] tdata;
  logic                                tvalid;
  logic                                tready;

  modport Source (input clk, output tdata, output tvalid, input tready);
  modport Sink   (input clk, input tdata, input tvalid, output tready);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: samples rxd mid-bit and presents good bytes through a
// single-entry AXI-Stream output register with one-cycle error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic          rst_n,
  input  logic          rxd,
  axis_interface.Source stream,
  output logic          framing_error,
  output logic          overrun_error
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic clk;
  assign clk = stream.clk;

  logic                      rst_sync_n;
  logic                      rxd_s;
  uart_rx_state_t            state;
  uart_rx_state_t            state_next;
  logic [CNT_W-1:0]          clk_cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [UART_DATA_BITS-1:0] tdata_q;
  logic                      tvalid_q;
  logic                      cnt_clr;
  logic                      bit_sample;
  logic                      byte_done;
  logic                      frame_bad;
  logic                      accept;

  // Reset asserts immediately but is released only on a clock edge.
  sync_2ff #(
    .WIDTH      (1),
    .RESET_VALUE(1'b0)
  ) u_rst_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (1'b1),
    .q    (rst_sync_n)
  );

  sync_2ff #(
    .WIDTH      (1),
    .RESET_VALUE(1'b1)
  ) u_rxd_sync (
    .clk  (clk),
    .rst_n(rst_sync_n),
    .d    (rxd),
    .q    (rxd_s)
  );

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state <= RX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    bit_sample = 1'b0;
    byte_done  = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_clr = 1'b1;
        if (!rxd_s) begin
          state_next = RX_START;
        end
      end
      RX_START: begin
        // A start bit that is high again by its midpoint is treated as noise.
        if (clk_cnt == HALF_CNT) begin
          cnt_clr    = 1'b1;
          state_next = rxd_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clk_cnt == LAST_CNT) begin
          cnt_clr    = 1'b1;
          bit_sample = 1'b1;
          if (bit_idx == LAST_BIT) begin
            state_next = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (clk_cnt == LAST_CNT) begin
          cnt_clr = 1'b1;
          if (rxd_s) begin
            byte_done  = 1'b1;
            state_next = RX_IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_next = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        cnt_clr = 1'b1;
        if (rxd_s) begin
          state_next = RX_IDLE;
        end
      end
      default: begin
        cnt_clr    = 1'b1;
        state_next = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      clk_cnt <= cnt_clr ? '0 : clk_cnt + CNT_W'(1);
      if (state == RX_IDLE) begin
        bit_idx <= '0;
      end else if (bit_sample) begin
        shift_reg[bit_idx] <= rxd_s;
        bit_idx            <= bit_idx + 3'd1;
      end
    end
  end

  // A new byte may overwrite the holding register only if it is empty or
  // being drained on this very edge.
  assign accept = !tvalid_q || stream.tready;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      framing_error <= frame_bad;
      overrun_error <= byte_done && !accept;
      if (byte_done && accept) begin
        tdata_q  <= shift_reg;
        tvalid_q <= 1'b1;
      end else if (tvalid_q && stream.tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign stream.tdata  = tdata_q;
  assign stream.tvalid = tvalid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame-level model predicts every output
// cycle, and per-test literal checks pin the delivered byte stream.
module tb_uart_rx;

  localparam int C = 16;
  // Cycles from rxd falling to the mid-stop sample: 2 sync + half bit + 9 bits.
  localparam int SAMPLE_OFS = 2 + C / 2 + 9 * C;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic rxd   = 1'b1;
  logic framing_error;
  logic overrun_error;

  axis_interface stream_if (.clk(clk));

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .rst_n        (rst_n),
    .rxd          (rxd),
    .stream       (stream_if),
    .framing_error(framing_error),
    .overrun_error(overrun_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cycle;
    bit         good;
    logic [7:0] data;
  } frame_evt_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  frame_evt_t evq[$];
  frame_evt_t ev_now;
  logic       m_tvalid = 1'b0;
  logic [7:0] m_tdata  = 8'h00;
  logic       m_fe     = 1'b0;
  logic       m_ovr    = 1'b0;

  logic [7:0] beats[$];
  int         fe_cnt      = 0;
  int         ovr_cnt     = 0;
  int         rise_cycle  = -1;
  int         tv_cycles   = 0;
  logic       prev_tvalid = 1'b0;

  // Frame-level model: a completed frame either loads the holding register,
  // overruns it, or raises a framing error; the consumer drains it on tready.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_tvalid = 1'b0;
      m_tdata  = 8'h00;
      m_fe     = 1'b0;
      m_ovr    = 1'b0;
      evq.delete();
    end else begin
      m_fe  = 1'b0;
      m_ovr = 1'b0;
      if (m_tvalid && stream_if.tready) m_tvalid = 1'b0;
      if (evq.size() > 0 && evq[0].cycle == cyc) begin
        ev_now = evq.pop_front();
        if (!ev_now.good) begin
          m_fe = 1'b1;
        end else if (!m_tvalid) begin
          m_tvalid = 1'b1;
          m_tdata  = ev_now.data;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    cyc = cyc + 1;
  end

  logic       e_tv;
  logic [7:0] e_td;
  logic       e_fe;
  logic       e_ov;
  logic       cyc_ok;

  always @(negedge clk) begin
    if (!rst_n) begin
      e_tv = 1'b0; e_td = 8'h00; e_fe = 1'b0; e_ov = 1'b0;
    end else begin
      e_tv = m_tvalid; e_td = m_tdata; e_fe = m_fe; e_ov = m_ovr;
    end
    cyc_ok = (stream_if.tvalid === e_tv) && (framing_error === e_fe) &&
             (overrun_error === e_ov) &&
             ((!e_tv && rst_n) || (stream_if.tdata === e_td));
    n_tests++;
    if (!cyc_ok) begin
      n_fail++;
      $display("[TB] FAIL cycle_%0d: got tvalid=%b tdata=%h fe=%b ovr=%b, want tvalid=%b tdata=%h fe=%b ovr=%b",
               cyc, stream_if.tvalid, stream_if.tdata, framing_error, overrun_error,
               e_tv, e_td, e_fe, e_ov);
    end
    if (stream_if.tvalid && stream_if.tready) beats.push_back(stream_if.tdata);
    if (framing_error) fe_cnt++;
    if (overrun_error) ovr_cnt++;
    if (stream_if.tvalid) tv_cycles++;
    if (stream_if.tvalid && !prev_tvalid) rise_cycle = cyc;
    prev_tvalid = stream_if.tvalid;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop, output int start);
    frame_evt_t ev;
    start    = cyc;
    ev.cycle = start + SAMPLE_OFS;
    ev.good  = stop;
    ev.data  = data;
    evq.push_back(ev);
    rxd = 1'b0;
    wait_cycles(C);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      wait_cycles(C);
    end
    rxd = stop;
    wait_cycles(C);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic start_test();
    beats.delete();
    fe_cnt     = 0;
    ovr_cnt    = 0;
    rise_cycle = -1;
    tv_cycles  = 0;
  endtask

  function automatic int beat_at(input int i);
    return (beats.size() > i) ? int'(beats[i]) : -1;
  endfunction

  int s;

  initial begin
    stream_if.tready = 1'b1;
    #1 rst_n = 1'b0;
    wait_cycles(3);
    checkOutput("reset_tvalid", stream_if.tvalid, 0);
    checkOutput("reset_tdata", stream_if.tdata, 0);
    checkOutput("reset_fe", framing_error, 0);
    checkOutput("reset_ovr", overrun_error, 0);
    rst_n = 1'b1;
    wait_cycles(C);

    start_test();
    applyStimulus(8'hA5, 1'b1, s);
    wait_cycles(C);
    checkOutput("a5_count", beats.size(), 1);
    checkOutput("a5_data", beat_at(0), 'hA5);
    checkOutput("a5_rise_cycle", rise_cycle - s, 155);
    checkOutput("a5_tvalid_cycles", tv_cycles, 1);
    checkOutput("a5_errors", fe_cnt + ovr_cnt, 0);

    start_test();
    applyStimulus(8'h00, 1'b1, s);
    applyStimulus(8'hFF, 1'b1, s);
    applyStimulus(8'h55, 1'b1, s);
    wait_cycles(C);
    checkOutput("b2b_count", beats.size(), 3);
    checkOutput("b2b_data0", beat_at(0), 'h00);
    checkOutput("b2b_data1", beat_at(1), 'hFF);
    checkOutput("b2b_data2", beat_at(2), 'h55);
    checkOutput("b2b_errors", fe_cnt + ovr_cnt, 0);

    start_test();
    rxd = 1'b0;
    wait_cycles(4);
    rxd = 1'b1;
    wait_cycles(2 * C);
    checkOutput("glitch_count", beats.size(), 0);
    checkOutput("glitch_errors", fe_cnt + ovr_cnt, 0);
    applyStimulus(8'hC3, 1'b1, s);
    wait_cycles(C);
    checkOutput("after_glitch_data", beat_at(0), 'hC3);

    start_test();
    applyStimulus(8'h3C, 1'b0, s);
    wait_cycles(40);
    rxd = 1'b1;
    wait_cycles(2 * C);
    checkOutput("break_fe_count", fe_cnt, 1);
    checkOutput("break_no_beat", beats.size(), 0);
    applyStimulus(8'h81, 1'b1, s);
    wait_cycles(C);
    checkOutput("break_recover_count", beats.size(), 1);
    checkOutput("break_recover_data", beat_at(0), 'h81);
    checkOutput("break_ovr_count", ovr_cnt, 0);

    start_test();
    stream_if.tready = 1'b0;
    applyStimulus(8'h11, 1'b1, s);
    applyStimulus(8'h22, 1'b1, s);
    wait_cycles(C);
    checkOutput("ovr_tvalid_held", stream_if.tvalid, 1);
    checkOutput("ovr_tdata_held", stream_if.tdata, 'h11);
    checkOutput("ovr_pulse_count", ovr_cnt, 1);
    checkOutput("ovr_fe_count", fe_cnt, 0);
    stream_if.tready = 1'b1;
    wait_cycles(C);
    checkOutput("ovr_drain_count", beats.size(), 1);
    checkOutput("ovr_drain_data", beat_at(0), 'h11);

    // Leave a byte pending, then reset in the middle of the next frame.
    start_test();
    stream_if.tready = 1'b0;
    applyStimulus(8'hE7, 1'b1, s);
    rxd = 1'b0;
    wait_cycles(C);
    for (int i = 0; i < 3; i++) begin
      rxd = s[0] ? 1'b1 : 1'b1;
      rxd = (8'h96 >> i) & 8'h01;
      wait_cycles(C);
    end
    rxd = 1'b0;
    wait_cycles(C / 2);
    checkOutput("pre_reset_tvalid", stream_if.tvalid, 1);
    rst_n = 1'b0;
    wait_cycles(2);
    checkOutput("midreset_tvalid", stream_if.tvalid, 0);
    checkOutput("midreset_tdata", stream_if.tdata, 0);
    checkOutput("midreset_errors", framing_error | overrun_error, 0);
    rxd = 1'b1;
    stream_if.tready = 1'b1;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2 * C);
    applyStimulus(8'h5A, 1'b1, s);
    wait_cycles(C);
    checkOutput("postreset_count", beats.size(), 1);
    checkOutput("postreset_data", beat_at(0), 'h5A);
    checkOutput("postreset_errors", fe_cnt + ovr_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of uart_tx.
- Sits downstream of the serial line:
  - oversamples rxd with the system clock;
  - deframes 8N1 characters;
  - presents each good byte on an AXI-Stream source (axis_interface.Source) for an RX queue or consumer.
- Reports framing and overrun errors as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 868, clocks per bit period (115200 bps at 100 MHz); legal range >= 4.

Ports:
- clk  input  1  system clock; carried as stream.clk of the axis_interface, no separate port.
- rst_n  input  1  asynchronous active-low reset.
- rxd  input  1  asynchronous serial input; idle high.
- stream  axis_interface.Source  -  stream.tdata[7:0] received byte, stream.tvalid, stream.tready from consumer.
- framing_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun_error  output  1  one-cycle pulse: byte completed while the previous byte was still unaccepted; new byte dropped.

Behaviour:
- Reset: async assert on rst_n low, sync release. Reset values:
  - state = RX_IDLE;
  - tvalid = 0, tdata = 0;
  - framing_error = 0, overrun_error = 0;
  - synchronizer flops = 1, counters = 0.
- Input synchronizer:
  - rxd passes through a 2-FF synchronizer to give rxd_s, a 2-cycle latency.
  - Only rxd_s is used internally.
- Bit counter: clk_cnt counts 0..CLKS_PER_BIT-1. bit_idx is 3 bits.
- RX_IDLE:
  - clk_cnt = 0, bit_idx = 0.
  - rxd_s == 0 moves to RX_START.
- RX_START: at clk_cnt == CLKS_PER_BIT/2 - 1 (integer divide), i.e. mid start bit:
  - rxd_s == 0: clk_cnt <= 0, go to RX_DATA.
  - rxd_s == 1: glitch; go to RX_IDLE with no output and no error.
- RX_DATA:
  - At clk_cnt == CLKS_PER_BIT-1, sample rxd_s into shift_reg[bit_idx] (LSB first) and clear clk_cnt.
  - After bit_idx == 7 is sampled, go to RX_STOP.
  - Sampling points are therefore mid-bit.
- RX_STOP: at clk_cnt == CLKS_PER_BIT-1 (mid stop bit):
  - rxd_s == 1 (good byte):
    - Byte is accepted for output if tvalid == 0, or if tvalid && tready in this same cycle. Then tdata <= shift_reg and tvalid <= 1 on the next edge.
    - Otherwise: overrun_error pulses for 1 cycle; old tdata and tvalid are held, new byte discarded.
    - Go to RX_IDLE.
  - rxd_s == 0: framing_error pulses for 1 cycle, byte discarded, go to RX_WAIT_HIGH.
- RX_WAIT_HIGH: stay until rxd_s == 1, then go to RX_IDLE. This prevents a break or a stuck-low line from being read as repeated start bits.
- Return to RX_IDLE happens at mid stop bit, so back-to-back characters with a 1-bit stop are received without loss.
- Output handshake:
  - tvalid clears on the edge where tvalid && tready.
  - tdata is stable while tvalid == 1.
  - Latency: tvalid rises 1 cycle after the mid-stop sample.
  - Single-entry output register; no deeper buffering.
- Simultaneous accept and new byte (tvalid && tready in the cycle the new byte completes): tdata is replaced, tvalid stays 1, no overrun.
- Reset mid-frame: the frame is abandoned, all state returns to reset values, and the next falling edge after release starts a new frame.
- Error pulses are mutually exclusive and each lasts exactly one clk.

Decomposition:
- uart_pkg (shared with uart_tx):
  - uart_rx_state_t enum: RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH;
  - DEFAULT_CLKS_PER_BIT = 868;
  - UART_DATA_BITS = 8.
- Sub-module sync_2ff: parameterised-width 2-flop synchronizer with async active-low reset and reset value parameter. Reusable for other async inputs.

Test Plan (bench uses CLKS_PER_BIT=16, tready held 1 unless stated):
- Send 0xA5 as 8N1 -> exactly one beat with tdata=0xA5, tvalid high for 1 cycle; no error pulses; tvalid rises 1 cycle after the mid-stop sample.
- Send 0x00, 0xFF, 0x55 back-to-back, no idle gap -> three beats in order 0x00, 0xFF, 0x55; no errors.
- Drive rxd low for 4 clocks, then high (glitch) -> no beat, no error, state returns to RX_IDLE.
- Send 0x3C with stop bit low, then hold rxd low 40 clocks, then high, then send 0x81:
  - framing_error pulses once;
  - no beat for 0x3C;
  - no spurious frames during the low period;
  - 0x81 is delivered.
- tready=0; send 0x11 then 0x22 ->
  - tvalid=1, tdata=0x11 held;
  - overrun_error pulses once at the 0x22 mid-stop sample;
  - raising tready yields only 0x11.
- Assert rst_n low mid-way through data bit 3 of 0x96, then release and send 0x5A -> all outputs at reset values during reset; the only beat delivered is 0x5A.
